// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Instruction-fetch stage: a program counter with prioritised redirect,
//   plus the IF/ID pipeline register that follows it. It also keeps a count
//   of fetched instructions and two sticky fault flags.
//
// Parameters
//   RESET_PC      PC value loaded on reset
//   IMEM_WORDS    number of valid instruction-memory words (index 0..N-1)
//
// Ports
//   Clk                 clock; all state updates on the rising edge
//   Rst                 synchronous active-high reset
//   Stall               holds PC and IF/ID; redirects are ignored while set
//   Flush               loads a NOP into IF/ID; takes priority over Stall
//                       for IF/ID only
//   Branch/BranchTarget taken-branch redirect (lowest redirect priority)
//   Jump/JumpIndex      J/JAL redirect using the instr[25:0] field
//   JumpReg/JumpRegTarget  JR redirect (highest redirect priority)
//   Address             byte address to instruction memory (equals PC)
//   Instruction         combinational read data from instruction memory
//   IFID_Instruction, IFID_PCPlus4, IFID_Valid   IF/ID register outputs
//   FetchCount          instructions loaded valid into IF/ID (wraps)
//   AddrFault           sticky: fetch attempted at PC beyond IMEM_WORDS
//   Misaligned          sticky: selected redirect target had nonzero [1:0]
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 513
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JumpReg,
  input  logic [31:0] JumpRegTarget,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] FetchCount,
  output logic        AddrFault,
  output logic        Misaligned
);

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pcp4_q, ifid_pcp4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        addr_fault_q, addr_fault_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] pc_plus4;
  logic        in_range;

  assign pc_plus4 = pc_q + 32'd4;
  assign in_range = (pc_q[31:2] < IMEM_LIMIT);

  // Next PC and alignment flag
  always_comb begin
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    if (!Stall) begin
      if (JumpReg) begin
        pc_d = {JumpRegTarget[31:2], 2'b00};
        if (JumpRegTarget[1:0] != 2'b00) misaligned_d = 1'b1;
      end else if (Jump) begin
        pc_d = {pc_plus4[31:28], JumpIndex, 2'b00};
      end else if (Branch) begin
        pc_d = {BranchTarget[31:2], 2'b00};
        if (BranchTarget[1:0] != 2'b00) misaligned_d = 1'b1;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  // IF/ID register, fetch counter and address fault
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pcp4_d  = ifid_pcp4_q;
    ifid_valid_d = ifid_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    addr_fault_d = addr_fault_q;
    if (Flush) begin
      ifid_instr_d = '0;
      ifid_pcp4_d  = pc_plus4;
      ifid_valid_d = 1'b0;
    end else if (!Stall) begin
      ifid_pcp4_d = pc_plus4;
      if (in_range) begin
        ifid_instr_d = Instruction;
        ifid_valid_d = 1'b1;
        fetch_cnt_d  = fetch_cnt_q + 32'd1;
      end else begin
        // Out-of-range fetch becomes a NOP bubble; PC still advances.
        ifid_instr_d = '0;
        ifid_valid_d = 1'b0;
        addr_fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= '0;
      ifid_pcp4_q  <= '0;
      ifid_valid_q <= 1'b0;
      fetch_cnt_q  <= '0;
      addr_fault_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pcp4_q  <= ifid_pcp4_d;
      ifid_valid_q <= ifid_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      addr_fault_q <= addr_fault_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign Address          = pc_q;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PCPlus4     = ifid_pcp4_q;
  assign IFID_Valid       = ifid_valid_q;
  assign FetchCount       = fetch_cnt_q;
  assign AddrFault        = addr_fault_q;
  assign Misaligned       = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch. Instruction memory is modelled as
//   memory[i] = i*4 for in-range words, and returns a junk pattern beyond
//   IMEM_WORDS so an out-of-range fetch that leaked through would be seen.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int unsigned WORDS = 513;

  logic        Clk = 1'b0;
  logic        Rst, Stall, Flush, Branch, Jump, JumpReg;
  logic [31:0] BranchTarget, JumpRegTarget;
  logic [25:0] JumpIndex;
  logic [31:0] Address, Instruction;
  logic [31:0] IFID_Instruction, IFID_PCPlus4, FetchCount;
  logic        IFID_Valid, AddrFault, Misaligned;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(WORDS)
  ) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Stall           (Stall),
    .Flush           (Flush),
    .Branch          (Branch),
    .BranchTarget    (BranchTarget),
    .Jump            (Jump),
    .JumpIndex       (JumpIndex),
    .JumpReg         (JumpReg),
    .JumpRegTarget   (JumpRegTarget),
    .Address         (Address),
    .Instruction     (Instruction),
    .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4    (IFID_PCPlus4),
    .IFID_Valid      (IFID_Valid),
    .FetchCount      (FetchCount),
    .AddrFault       (AddrFault),
    .Misaligned      (Misaligned)
  );

  always #5 Clk = ~Clk;

  assign Instruction = (Address[31:2] < 30'(WORDS)) ? {Address[31:2], 2'b00}
                                                    : 32'hDEAD_BEEF;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Rst = 0; Stall = 0; Flush = 0; Branch = 0; Jump = 0; JumpReg = 0;
    BranchTarget = '0; JumpRegTarget = '0; JumpIndex = '0;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc,
                           input logic [31:0] ins, input logic [31:0] pcp4,
                           input logic vld, input logic [31:0] cnt,
                           input logic af, input logic mis);
    check_val({tag, ".pc"},    Address, pc);
    check_val({tag, ".instr"}, IFID_Instruction, ins);
    check_val({tag, ".pcp4"},  IFID_PCPlus4, pcp4);
    check_val({tag, ".valid"}, 32'(IFID_Valid), 32'(vld));
    check_val({tag, ".cnt"},   FetchCount, cnt);
    check_val({tag, ".af"},    32'(AddrFault), 32'(af));
    check_val({tag, ".mis"},   32'(Misaligned), 32'(mis));
  endtask

  initial begin
    // Reset with every other input active
    idle_inputs();
    Rst = 1; Stall = 1; Flush = 1; Branch = 1; Jump = 1; JumpReg = 1;
    BranchTarget = 32'h83; JumpRegTarget = 32'h41; JumpIndex = 26'h10;
    step();
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0);
    idle_inputs();

    // Sequential run
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("seq.instr", IFID_Instruction, 32'(k * 4));
      check_val("seq.pcp4",  IFID_PCPlus4, 32'(k * 4 + 4));
    end
    check_all("seq.end", 32'h10, 32'h0C, 32'h10, 1'b1, 32'd4, 1'b0, 1'b0);

    // Stall for three cycles
    Stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_all("stall", 32'h10, 32'h0C, 32'h10, 1'b1, 32'd4, 1'b0, 1'b0);
    end
    Stall = 0;
    step();
    check_all("stall.rel", 32'h14, 32'h10, 32'h14, 1'b1, 32'd5, 1'b0, 1'b0);
    step(); step(); step();
    check_val("pc20", Address, 32'h20);

    // Redirect priority
    JumpReg = 1; JumpRegTarget = 32'h40;
    Jump = 1; JumpIndex = 26'h10;
    Branch = 1; BranchTarget = 32'h80;
    step();
    check_all("jr", 32'h40, 32'h20, 32'h24, 1'b1, 32'd9, 1'b0, 1'b0);
    JumpReg = 0;
    step();
    check_all("jmp", 32'h40, 32'h40, 32'h44, 1'b1, 32'd10, 1'b0, 1'b0);
    Jump = 0; BranchTarget = 32'h83;
    step();
    check_all("br.mis", 32'h80, 32'h40, 32'h44, 1'b1, 32'd11, 1'b0, 1'b1);
    Branch = 0;

    // Flush with and without stall
    Flush = 1; Stall = 1;
    step();
    check_all("flush.stall", 32'h80, 32'h0, 32'h84, 1'b0, 32'd11, 1'b0, 1'b1);
    Stall = 0;
    step();
    check_all("flush", 32'h84, 32'h0, 32'h84, 1'b0, 32'd11, 1'b0, 1'b1);
    Flush = 0;

    // Memory boundary: last valid word, then first invalid word
    Branch = 1; BranchTarget = 32'h800;
    step();
    check_all("br800", 32'h800, 32'h84, 32'h88, 1'b1, 32'd12, 1'b0, 1'b1);
    Branch = 0;
    step();
    check_all("last.word", 32'h804, 32'h800, 32'h804, 1'b1, 32'd13, 1'b0, 1'b1);
    step();
    check_all("oob", 32'h808, 32'h0, 32'h808, 1'b0, 32'd13, 1'b1, 1'b1);

    // PC wrap from 0xFFFF_FFFC
    JumpReg = 1; JumpRegTarget = 32'hFFFF_FFFC;
    step();
    check_val("jr.top", Address, 32'hFFFF_FFFC);
    JumpReg = 0;
    step();
    check_all("wrap", 32'h0, 32'h0, 32'h0, 1'b0, 32'd13, 1'b1, 1'b1);
    step();
    check_all("post.wrap", 32'h4, 32'h0, 32'h4, 1'b1, 32'd14, 1'b1, 1'b1);

    // Redirect ignored while stalled, then reset discards it
    Stall = 1; Branch = 1; BranchTarget = 32'h100;
    step();
    check_all("stall.br", 32'h4, 32'h0, 32'h4, 1'b1, 32'd14, 1'b1, 1'b1);
    Rst = 1;
    step();
    check_all("rst.mid", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0);
    idle_inputs();
    step();
    check_all("rst.rel", 32'h4, 32'h0, 32'h4, 1'b1, 32'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
